wb_pc_sequencer: RTL and testbench
==================================

Name: wb_pc_sequencer

Overview:
- Parametrised successor to the combined write-back / PC-generation stage.
- Registers the last pipeline stage, selects write-back data, and computes the next fetch PC from four sources: sequential, conditional branch, direct jump, register jump.
- Adds blocking UART handshakes with an explicit FSM and a stall output to the upstream stages.
- Adds r0 write suppression and a configurable reset PC.

Parameters:
INST_MEM_WIDTH, 14, PC / instruction-address width in words
DATA_WIDTH, 32, register and data-path width
RESET_PC, 0, PC value presented after reset

Ports:
CLK  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_in  in  1  instruction present in stage
reg_write  in  1  instruction writes a register
wb_sel  in  2  00 ALU, 01 memory, 10 link (pc+1), 11 UART input
uart_out_req  in  1  instruction transmits alu_result[7:0]
branch  in  2  00 sequential, 01 conditional (taken if alu_result==0), 10 direct jump, 11 register jump
alu_result  in  DATA_WIDTH  ALU output
read_data  in  DATA_WIDTH  memory read data
register_data  in  DATA_WIDTH  jump-register source
inst_index  in  26  direct-jump field; low INST_MEM_WIDTH bits used
branch_target  in  INST_MEM_WIDTH  precomputed conditional target
pc  in  INST_MEM_WIDTH  PC of this instruction
rd  in  5  destination register
uart_rx_valid  in  1  receive byte available
uart_rx_data  in  8  received byte
uart_rx_ack  out  1  receive byte consumed
uart_tx_ready  in  1  transmitter can accept
uart_tx_valid  out  1  transmit request
uart_tx_data  out  8  transmit byte
stall  out  1  upstream must hold its instruction
wb_en  out  1  register-file write enable
wb_rd  out  5  write address
wb_data  out  DATA_WIDTH  write data
pc_out  out  INST_MEM_WIDTH  next fetch PC
pc_out_plus1  out  INST_MEM_WIDTH  pc_out+1
pc_update  out  1  one-cycle pulse: pc_out is new
retired_count  out  32  retired-instruction count (optional feature)

Behaviour:
- Reset (reset==0, asynchronous):
  - state=RUN; wb_en=0, wb_rd=0, wb_data=0.
  - pc_out=RESET_PC, pc_out_plus1=RESET_PC+1, pc_update=0.
  - uart_tx_valid=0, uart_tx_data=0; retired_count=0.
  - Reset asserted mid-handshake abandons the captured instruction; no commit occurs.
- FSM states:
  - RUN: stall=0.
  - WAIT_IN: stall=1; uart_rx_ack = uart_rx_valid (combinational).
  - WAIT_OUT: stall=1; uart_tx_valid=1; uart_tx_data holds the captured alu_result[7:0].
- Capture: in RUN with valid_in=1, all inputs are latched into a holding register.
  - wb_sel==11 → WAIT_IN.
  - Else uart_out_req==1 → WAIT_OUT.
  - Else commit at this edge (1-cycle latency).
  - wb_sel==11 with uart_out_req==1: uart_out_req is ignored.
- Leaving the wait states:
  - WAIT_IN: on an edge with uart_rx_valid=1, commit with wb_data = zero-extended uart_rx_data, then return to RUN.
  - WAIT_OUT: on an edge with uart_tx_ready=1, commit, then return to RUN; uart_tx_valid drops in the same cycle.
- Commit (registered):
  - wb_en = reg_write && rd!=0; wb_rd = rd.
  - wb_data by wb_sel; link data = pc+1 zero-extended to DATA_WIDTH.
  - pc_out by branch:
    - 00: pc+1.
    - 01: branch_target if alu_result==0, else pc+1.
    - 10: inst_index[INST_MEM_WIDTH-1:0].
    - 11: register_data[INST_MEM_WIDTH-1:0].
  - pc_update=1 for exactly one cycle.
- Hold: on cycles without a commit, wb_en=0, pc_update=0, and pc_out / pc_out_plus1 hold their values.
- Arithmetic: all PC arithmetic is modulo 2^INST_MEM_WIDTH; pc at all-ones gives pc+1 = 0.
- valid_in=0 in RUN: no state change.
- Inputs other than UART signals are ignored while stall=1.

Optional Feature:
- WBPC_RETIRE_CNT_EN defined: retired_count increments by 1 on each commit and wraps at 2^32.
- Not defined: retired_count is tied to 0 and no counter flops exist.

Decomposition:
- Package wb_pc_pkg holds:
  - wb_sel_e (WB_ALU, WB_MEM, WB_LINK, WB_UART).
  - branch_e (BR_SEQ, BR_COND, BR_JUMP, BR_JREG).
  - state_e (RUN, WAIT_IN, WAIT_OUT).
- One sub-module, wb_pc_next_pc: combinational next-PC select and +1 adder, parametrised by INST_MEM_WIDTH.

Test Plan:
- Reset release with RESET_PC=5 → pc_out=5, pc_out_plus1=6, pc_update=0, wb_en=0.
- ALU op: rd=3, alu_result=0x1234, pc=10, branch=00 → next cycle wb_en=1, wb_rd=3, wb_data=0x1234, pc_out=11, one pc_update pulse.
- rd=0 with reg_write=1 → wb_en=0; pc still advances.
- Conditional branch, INST_MEM_WIDTH=4:
  - alu_result=0, branch_target=7 → pc_out=7.
  - alu_result=1, pc=15 → pc_out=0 (wrap).
- UART input: wb_sel=11, rx_valid low for 3 cycles → stall=1 for 3 cycles, then rx_data=0x41 → rx_ack pulse, wb_data=0x00000041, stall=0.
- UART output: alu_result=0x5A, tx_ready low 2 cycles → tx_valid high, tx_data=0x5A held; commit on the ready edge; async reset mid-wait → state RUN, tx_valid=0, no commit.

Source files
------------

// File: rtl/wb_pc_sequencer_pkg.sv
// Shared encodings for the write-back / next-PC sequencer.
package wb_pc_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_UART = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        BR_SEQ  = 2'b00,
        BR_COND = 2'b01,
        BR_JUMP = 2'b10,
        BR_JREG = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT_IN  = 2'b01,
        WAIT_OUT = 2'b10
    } state_e;

endpackage

// File: rtl/wb_pc_sequencer_next_pc.sv
// Combinational next-PC select; all arithmetic wraps modulo 2^INST_MEM_WIDTH.
module wb_pc_next_pc
    import wb_pc_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14
) (
    input  branch_e                   branch,
    input  logic                      cond_zero,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] branch_target,
    input  logic [INST_MEM_WIDTH-1:0] jump_target,
    input  logic [INST_MEM_WIDTH-1:0] reg_target,
    output logic [INST_MEM_WIDTH-1:0] pc_plus1,
    output logic [INST_MEM_WIDTH-1:0] next_pc,
    output logic [INST_MEM_WIDTH-1:0] next_pc_plus1
);

    localparam logic [INST_MEM_WIDTH-1:0] ONE = 1;

    always_comb begin
        pc_plus1 = pc + ONE;
        next_pc  = pc_plus1;
        case (branch)
            BR_SEQ:  next_pc = pc_plus1;
            BR_COND: next_pc = cond_zero ? branch_target : pc_plus1;
            BR_JUMP: next_pc = jump_target;
            BR_JREG: next_pc = reg_target;
            default: next_pc = pc_plus1;
        endcase
        next_pc_plus1 = next_pc + ONE;
    end

endmodule

// File: rtl/wb_pc_sequencer.sv
// Write-back select, next-PC generation and blocking UART handshakes.
// Optional retired-instruction counter enabled by defining WBPC_RETIRE_CNT_EN.
module wb_pc_sequencer
    import wb_pc_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int RESET_PC       = 0
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic                      reg_write,
    input  logic [1:0]                wb_sel,
    input  logic                      uart_out_req,
    input  logic [1:0]                branch,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic [DATA_WIDTH-1:0]     register_data,
    input  logic [25:0]               inst_index,
    input  logic [INST_MEM_WIDTH-1:0] branch_target,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [4:0]                rd,
    input  logic                      uart_rx_valid,
    input  logic [7:0]                uart_rx_data,
    output logic                      uart_rx_ack,
    input  logic                      uart_tx_ready,
    output logic                      uart_tx_valid,
    output logic [7:0]                uart_tx_data,
    output logic                      stall,
    output logic                      wb_en,
    output logic [4:0]                wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [INST_MEM_WIDTH-1:0] pc_out,
    output logic [INST_MEM_WIDTH-1:0] pc_out_plus1,
    output logic                      pc_update,
    output logic [31:0]               retired_count
);

    localparam logic [INST_MEM_WIDTH-1:0] ONE       = 1;
    localparam logic [INST_MEM_WIDTH-1:0] RST_PC    = INST_MEM_WIDTH'(RESET_PC);
    localparam logic [INST_MEM_WIDTH-1:0] RST_PC_P1 = RST_PC + ONE;

    state_e state;

    // Instruction held across a UART wait
    logic                      h_reg_write;
    wb_sel_e                   h_wb_sel;
    branch_e                   h_branch;
    logic [DATA_WIDTH-1:0]     h_alu, h_read, h_regd;
    logic [INST_MEM_WIDTH-1:0] h_jump, h_target, h_pc;
    logic [4:0]                h_rd;

    logic                      c_reg_write;
    wb_sel_e                   c_wb_sel;
    branch_e                   c_branch;
    logic [DATA_WIDTH-1:0]     c_alu, c_read, c_regd;
    logic [INST_MEM_WIDTH-1:0] c_jump, c_target, c_pc;
    logic [4:0]                c_rd;

    logic                      commit;
    logic [DATA_WIDTH-1:0]     wb_data_nxt;
    logic [INST_MEM_WIDTH-1:0] link, next_pc, next_pc_plus1;

    logic unused_bits;
    assign unused_bits = ^{inst_index[25:INST_MEM_WIDTH], register_data[DATA_WIDTH-1:INST_MEM_WIDTH]};

    // A direct commit in RUN uses the live inputs; wait states use the held copy
    always_comb begin
        if (state == RUN) begin
            c_reg_write = reg_write;
            c_wb_sel    = wb_sel_e'(wb_sel);
            c_branch    = branch_e'(branch);
            c_alu       = alu_result;
            c_read      = read_data;
            c_regd      = register_data;
            c_jump      = inst_index[INST_MEM_WIDTH-1:0];
            c_target    = branch_target;
            c_pc        = pc;
            c_rd        = rd;
        end else begin
            c_reg_write = h_reg_write;
            c_wb_sel    = h_wb_sel;
            c_branch    = h_branch;
            c_alu       = h_alu;
            c_read      = h_read;
            c_regd      = h_regd;
            c_jump      = h_jump;
            c_target    = h_target;
            c_pc        = h_pc;
            c_rd        = h_rd;
        end
    end

    wb_pc_next_pc #(.INST_MEM_WIDTH(INST_MEM_WIDTH)) u_next_pc (
        .branch        (c_branch),
        .cond_zero     (c_alu == '0),
        .pc            (c_pc),
        .branch_target (c_target),
        .jump_target   (c_jump),
        .reg_target    (c_regd[INST_MEM_WIDTH-1:0]),
        .pc_plus1      (link),
        .next_pc       (next_pc),
        .next_pc_plus1 (next_pc_plus1)
    );

    always_comb begin
        case (c_wb_sel)
            WB_ALU:  wb_data_nxt = c_alu;
            WB_MEM:  wb_data_nxt = c_read;
            WB_LINK: wb_data_nxt = {{(DATA_WIDTH-INST_MEM_WIDTH){1'b0}}, link};
            WB_UART: wb_data_nxt = {{(DATA_WIDTH-8){1'b0}}, uart_rx_data};
            default: wb_data_nxt = c_alu;
        endcase
    end

    assign commit = (state == RUN && valid_in && wb_sel_e'(wb_sel) != WB_UART && !uart_out_req)
                 || (state == WAIT_IN && uart_rx_valid)
                 || (state == WAIT_OUT && uart_tx_ready);

    assign stall       = (state != RUN);
    assign uart_rx_ack = (state == WAIT_IN) && uart_rx_valid;

    always_ff @(posedge CLK) begin
        if (state == RUN && valid_in) begin
            h_reg_write <= reg_write;
            h_wb_sel    <= wb_sel_e'(wb_sel);
            h_branch    <= branch_e'(branch);
            h_alu       <= alu_result;
            h_read      <= read_data;
            h_regd      <= register_data;
            h_jump      <= inst_index[INST_MEM_WIDTH-1:0];
            h_target    <= branch_target;
            h_pc        <= pc;
            h_rd        <= rd;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            wb_en         <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            pc_out        <= RST_PC;
            pc_out_plus1  <= RST_PC_P1;
            pc_update     <= 1'b0;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
        end else begin
            wb_en     <= 1'b0;
            pc_update <= 1'b0;
            if (commit) begin
                wb_en        <= c_reg_write && (c_rd != 5'd0);
                wb_rd        <= c_rd;
                wb_data      <= wb_data_nxt;
                pc_out       <= next_pc;
                pc_out_plus1 <= next_pc_plus1;
                pc_update    <= 1'b1;
            end
            case (state)
                RUN: if (valid_in) begin
                    if (wb_sel_e'(wb_sel) == WB_UART) begin
                        state <= WAIT_IN;
                    end else if (uart_out_req) begin
                        state         <= WAIT_OUT;
                        uart_tx_valid <= 1'b1;
                        uart_tx_data  <= alu_result[7:0];
                    end
                end
                WAIT_IN:  if (uart_rx_valid) state <= RUN;
                WAIT_OUT: if (uart_tx_ready) begin
                    state         <= RUN;
                    uart_tx_valid <= 1'b0;
                end
                default:  state <= RUN;
            endcase
        end
    end

`ifdef WBPC_RETIRE_CNT_EN
    logic [31:0] retire_q;
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)      retire_q <= '0;
        else if (commit) retire_q <= retire_q + 32'd1;
    end
    assign retired_count = retire_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_wb_pc_sequencer.sv
// Directed vector bench for wb_pc_sequencer (INST_MEM_WIDTH=4, RESET_PC=5).
module tb_wb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        valid_in, reg_write, uart_out_req;
    logic [1:0]  wb_sel, branch;
    logic [31:0] alu_result, read_data, register_data;
    logic [25:0] inst_index;
    logic [3:0]  branch_target, pc;
    logic [4:0]  rd;
    logic        uart_rx_valid, uart_rx_ack, uart_tx_ready, uart_tx_valid;
    logic [7:0]  uart_rx_data, uart_tx_data;
    logic        stall, wb_en, pc_update;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, retired_count;
    logic [3:0]  pc_out, pc_out_plus1;

    int n_cmp = 0;
    int n_err = 0;

    wb_pc_sequencer #(.INST_MEM_WIDTH(4), .DATA_WIDTH(32), .RESET_PC(5)) dut (
        .CLK(CLK), .reset(reset), .valid_in(valid_in), .reg_write(reg_write),
        .wb_sel(wb_sel), .uart_out_req(uart_out_req), .branch(branch),
        .alu_result(alu_result), .read_data(read_data), .register_data(register_data),
        .inst_index(inst_index), .branch_target(branch_target), .pc(pc), .rd(rd),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ack(uart_rx_ack),
        .uart_tx_ready(uart_tx_ready), .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_out(pc_out), .pc_out_plus1(pc_out_plus1), .pc_update(pc_update),
        .retired_count(retired_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [1:0]  sel;
        logic [1:0]  br;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] regd;
        logic [25:0] idx;
        logic [3:0]  tgt;
        logic [3:0]  pcv;
        logic [4:0]  rdv;
        logic        en;
        logic [31:0] data;
        logic [3:0]  npc;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid_in = 0; reg_write = 0; wb_sel = 2'b00; uart_out_req = 0; branch = 2'b00;
        alu_result = 0; read_data = 0; register_data = 0; inst_index = 0;
        branch_target = 0; pc = 0; rd = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [3:0] exp_p1;
        int exp_retired;
        idle();
        reset = 0; uart_rx_valid = 0; uart_rx_data = 0; uart_tx_ready = 0;

        vt[0] = '{1, 2'b00, 2'b00, 32'h1234, 32'h0, 32'h0, 26'h0, 4'd0, 4'd10, 5'd3, 1, 32'h1234, 4'd11};
        vt[1] = '{1, 2'b00, 2'b00, 32'h55, 32'h0, 32'h0, 26'h0, 4'd0, 4'd11, 5'd0, 0, 32'h55, 4'd12};
        vt[2] = '{0, 2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 26'h0, 4'd7, 4'd3, 5'd4, 0, 32'h0, 4'd7};
        vt[3] = '{0, 2'b00, 2'b01, 32'h1, 32'h0, 32'h0, 26'h0, 4'd7, 4'd15, 5'd0, 0, 32'h1, 4'd0};
        vt[4] = '{1, 2'b01, 2'b10, 32'h9, 32'hDEADBEEF, 32'h0, 26'h3FFFFF9, 4'd2, 4'd2, 5'd7, 1, 32'hDEADBEEF, 4'd9};
        vt[5] = '{1, 2'b10, 2'b11, 32'h3, 32'h0, 32'hABCD0006, 26'h0, 4'd2, 4'd8, 5'd31, 1, 32'h9, 4'd6};

        repeat (2) tick();
        @(negedge CLK) reset = 1;
        tick();
        chk("rst_pc_out", 32'(pc_out), 32'd5);
        chk("rst_pc_p1", 32'(pc_out_plus1), 32'd6);
        chk("rst_pc_update", 32'(pc_update), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
        chk("rst_retired", retired_count, 32'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            valid_in = 1; reg_write = vt[i].rw; wb_sel = vt[i].sel; branch = vt[i].br;
            alu_result = vt[i].alu; read_data = vt[i].rdat; register_data = vt[i].regd;
            inst_index = vt[i].idx; branch_target = vt[i].tgt; pc = vt[i].pcv; rd = vt[i].rdv;
            tick();
            exp_p1 = vt[i].npc + 4'd1;
            chk($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(vt[i].en));
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vt[i].rdv));
            chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].data);
            chk($sformatf("v%0d_pc_out", i), 32'(pc_out), 32'(vt[i].npc));
            chk($sformatf("v%0d_pc_p1", i), 32'(pc_out_plus1), 32'(exp_p1));
            chk($sformatf("v%0d_pc_update", i), 32'(pc_update), 32'd1);
            @(negedge CLK) idle();
            tick();
            chk($sformatf("v%0d_hold_upd", i), 32'(pc_update), 32'd0);
            chk($sformatf("v%0d_hold_en", i), 32'(wb_en), 32'd0);
            chk($sformatf("v%0d_hold_pc", i), 32'(pc_out), 32'(vt[i].npc));
        end

        // UART input: three cycles without data, then byte 0x41
        @(negedge CLK);
        valid_in = 1; reg_write = 1; wb_sel = 2'b11; rd = 5'd9; pc = 4'd4; uart_out_req = 1;
        tick();
        @(negedge CLK);
        valid_in = 1; wb_sel = 2'b00; rd = 5'd2; pc = 4'd14; uart_out_req = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            chk($sformatf("rx_stall%0d", c), 32'(stall), 32'd1);
            chk($sformatf("rx_noack%0d", c), 32'(uart_rx_ack), 32'd0);
            chk($sformatf("rx_nocommit%0d", c), 32'(pc_update), 32'd0);
        end
        @(negedge CLK);
        uart_rx_valid = 1; uart_rx_data = 8'h41; valid_in = 0;
        #1 chk("rx_ack", 32'(uart_rx_ack), 32'd1);
        tick();
        chk("rx_wb_en", 32'(wb_en), 32'd1);
        chk("rx_wb_rd", 32'(wb_rd), 32'd9);
        chk("rx_wb_data", wb_data, 32'h41);
        chk("rx_pc_out", 32'(pc_out), 32'd5);
        chk("rx_stall_clr", 32'(stall), 32'd0);
        chk("rx_pc_update", 32'(pc_update), 32'd1);
        @(negedge CLK);
        uart_rx_valid = 0; idle();
        #1 chk("rx_ack_clr", 32'(uart_rx_ack), 32'd0);

        // UART output: transmitter busy for two cycles
        @(negedge CLK);
        valid_in = 1; reg_write = 1; uart_out_req = 1; alu_result = 32'h5A; rd = 5'd6; pc = 4'd12;
        tick();
        chk("tx_valid0", 32'(uart_tx_valid), 32'd1);
        chk("tx_data0", 32'(uart_tx_data), 32'h5A);
        chk("tx_stall0", 32'(stall), 32'd1);
        chk("tx_nocommit0", 32'(wb_en), 32'd0);
        @(negedge CLK) begin idle(); alu_result = 32'h0; end
        tick();
        chk("tx_valid1", 32'(uart_tx_valid), 32'd1);
        chk("tx_data1", 32'(uart_tx_data), 32'h5A);
        chk("tx_nocommit1", 32'(pc_update), 32'd0);
        @(negedge CLK) uart_tx_ready = 1;
        tick();
        chk("tx_wb_en", 32'(wb_en), 32'd1);
        chk("tx_wb_rd", 32'(wb_rd), 32'd6);
        chk("tx_wb_data", wb_data, 32'h5A);
        chk("tx_pc_out", 32'(pc_out), 32'd13);
        chk("tx_valid_clr", 32'(uart_tx_valid), 32'd0);
        chk("tx_stall_clr", 32'(stall), 32'd0);
        @(negedge CLK) uart_tx_ready = 0;

`ifdef WBPC_RETIRE_CNT_EN
        exp_retired = 8;
`else
        exp_retired = 0;
`endif
        chk("retired", retired_count, 32'(exp_retired));

        // Reset in the middle of a transmit wait abandons the instruction
        @(negedge CLK);
        valid_in = 1; reg_write = 1; uart_out_req = 1; alu_result = 32'h77; rd = 5'd8; pc = 4'd1;
        tick();
        chk("ab_tx_valid", 32'(uart_tx_valid), 32'd1);
        @(negedge CLK) idle();
        @(negedge CLK) reset = 0;
        #1;
        chk("ab_rst_tx_valid", 32'(uart_tx_valid), 32'd0);
        chk("ab_rst_stall", 32'(stall), 32'd0);
        chk("ab_rst_pc", 32'(pc_out), 32'd5);
        @(negedge CLK) begin reset = 1; uart_tx_ready = 1; end
        tick();
        chk("ab_no_en", 32'(wb_en), 32'd0);
        chk("ab_no_upd", 32'(pc_update), 32'd0);
        chk("ab_pc_hold", 32'(pc_out), 32'd5);
        chk("ab_no_retire", retired_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
